// File: rtl/pixie_video_gen.sv
// pixie_video_gen: CDP1861-style video generator with a row-fetch DMA engine.
//
// Counts pixel ticks (h) and lines (v) on clk_enable. On fetch lines it requests
// BYTES_PER_ROW bytes over DMA (DMAO low) and captures them when the CPU answers
// with SC==2. At the end of each fetch line the captured row moves to the display
// buffer and is shown, MSB first, on the following LINE_REPEAT lines.
//
// Ports:
//   clk, reset             video clock, synchronous active-high reset
//   clk_enable             pixel tick; all state advances only on it
//   SC[1:0]                CPU state code (2 = DMA cycle, 3 = interrupt acknowledge)
//   disp_on, disp_off      display enable control (disp_on wins)
//   data_in[7:0]           DMA bus data
//   video                  registered pixel, 1 tick latency
//   HSync, VSync           registered syncs, aligned with video
//   HBlank, VBlank         registered blanking, aligned with video
//   csync, video_de        composite sync and data enable derived from the above
//   DMAO                   active-low DMA request
//   INT                    active-high interrupt request
//   EFx                    active-low frame flag
//   dma_underrun           sticky short-row flag (only with PIXIE_UNDERRUN_EN)
//
// Option: define PIXIE_UNDERRUN_EN to add dma_underrun and zero-fill short rows.
module pixie_video_gen #(
  parameter int LINES_PER_FRAME    = 262,
  parameter int PIXELS_PER_LINE    = 112,
  parameter int DISPLAY_START_LINE = 64,
  parameter int DISPLAY_LINES      = 128,
  parameter int BYTES_PER_ROW      = 8,
  parameter int LINE_REPEAT        = 4,
  parameter int H_ACTIVE_START     = 16,
  parameter int DMA_START          = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic [1:0] SC,
  input  logic       disp_on,
  input  logic       disp_off,
  input  logic [7:0] data_in,
  output logic       video,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank,
  output logic       csync,
  output logic       video_de,
  output logic       DMAO,
  output logic       INT,
  output logic       EFx
`ifdef PIXIE_UNDERRUN_EN
  ,
  output logic       dma_underrun
`endif
);

  localparam int HW   = $clog2(PIXELS_PER_LINE);
  localparam int VW   = $clog2(LINES_PER_FRAME);
  localparam int PW   = $clog2(BYTES_PER_ROW + 1);
  localparam int BUFW = 8 * BYTES_PER_ROW;

  logic [HW-1:0]   h_q;
  logic [VW-1:0]   v_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BUFW-1:0] fetch_q, fetch_d;
  logic [BUFW-1:0] disp_q, disp_d;
  logic            disp_en_q;
  logic            int_q;
  logic            video_q, hsync_q, vsync_q, hblank_q, vblank_q;
`ifdef PIXIE_UNDERRUN_EN
  logic            underrun_q;
  logic            underrun_set;
`endif

  int              hi, vi;
  logic            h_last, v_last, fetch_line, dma_win, vis_h, vis_v;
  logic            capture, row_end;
  logic [HW-1:0]   pix_off;
  int              pix_sel;
  logic            pix_bit;
  logic [PW-1:0]   row_cnt;

  always_comb begin
    hi         = int'(h_q);
    vi         = int'(v_q);
    h_last     = (hi == PIXELS_PER_LINE - 1);
    v_last     = (vi == LINES_PER_FRAME - 1);
    fetch_line = (vi >= DISPLAY_START_LINE - 1) &&
                 (vi < DISPLAY_START_LINE - 1 + DISPLAY_LINES) &&
                 (((vi - (DISPLAY_START_LINE - 1)) % LINE_REPEAT) == 0);
    dma_win    = (hi >= DMA_START) && (hi < DMA_START + 8 * BYTES_PER_ROW);
    vis_h      = (hi >= H_ACTIVE_START) && (hi < H_ACTIVE_START + 8 * BYTES_PER_ROW);
    vis_v      = (vi >= DISPLAY_START_LINE) && (vi < DISPLAY_START_LINE + DISPLAY_LINES);
    // Byte b sits at bits [8b +: 8]; pixel k of that byte is bit 7-k, i.e. offset ^ 7.
    pix_off    = h_q - HW'(H_ACTIVE_START);
    pix_sel    = int'(pix_off ^ HW'(7));
    pix_bit    = 1'b0;
    for (int i = 0; i < BUFW; i++) begin
      if (pix_sel == i) pix_bit = disp_q[i];
    end
  end

  assign DMAO = ~(disp_en_q & fetch_line & dma_win);

  assign capture = ~DMAO & clk_enable & (SC == 2'd2) &
                   (wr_ptr_q != PW'(BYTES_PER_ROW));
  assign row_end = clk_enable & h_last & fetch_line;

  // Capture and row hand-off; a byte captured on the wrap tick still makes the row.
  always_comb begin
    fetch_d  = fetch_q;
    wr_ptr_d = wr_ptr_q;
    disp_d   = disp_q;
    row_cnt  = wr_ptr_q;
`ifdef PIXIE_UNDERRUN_EN
    underrun_set = 1'b0;
`endif
    if (capture) begin
      for (int i = 0; i < BYTES_PER_ROW; i++) begin
        if (wr_ptr_q == PW'(i)) fetch_d[8*i +: 8] = data_in;
      end
      wr_ptr_d = wr_ptr_q + 1'b1;
      row_cnt  = wr_ptr_q + 1'b1;
    end
    if (row_end) begin
      wr_ptr_d = '0;
      // Disabled display leaves the shown row untouched.
      if (disp_en_q) begin
        for (int i = 0; i < BYTES_PER_ROW; i++) begin
          if (PW'(i) < row_cnt) disp_d[8*i +: 8] = fetch_d[8*i +: 8];
`ifdef PIXIE_UNDERRUN_EN
          else disp_d[8*i +: 8] = 8'h00;
`endif
        end
`ifdef PIXIE_UNDERRUN_EN
        underrun_set = (row_cnt < PW'(BYTES_PER_ROW));
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      wr_ptr_q   <= '0;
      fetch_q    <= '0;
      disp_q     <= '0;
      disp_en_q  <= 1'b0;
      int_q      <= 1'b0;
      video_q    <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
`ifdef PIXIE_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else if (clk_enable) begin
      if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
      wr_ptr_q <= wr_ptr_d;
      fetch_q  <= fetch_d;
      disp_q   <= disp_d;
      if (disp_on)       disp_en_q <= 1'b1;
      else if (disp_off) disp_en_q <= 1'b0;
      if (disp_en_q && vi == DISPLAY_START_LINE - 2 && hi == 0) int_q <= 1'b1;
      else if ((vi == DISPLAY_START_LINE && hi == 0) || SC == 2'd3) int_q <= 1'b0;
      video_q  <= disp_en_q & vis_h & vis_v & pix_bit;
      hsync_q  <= (hi >= 2) && (hi < 10);
      vsync_q  <= (vi >= 2) && (vi < 4);
      hblank_q <= ~vis_h;
      vblank_q <= ~vis_v;
`ifdef PIXIE_UNDERRUN_EN
      if (disp_on)           underrun_q <= 1'b0;
      else if (underrun_set) underrun_q <= 1'b1;
`endif
    end
  end

  assign video    = video_q;
  assign HSync    = hsync_q;
  assign VSync    = vsync_q;
  assign HBlank   = hblank_q;
  assign VBlank   = vblank_q;
  assign csync    = ~(hsync_q ^ vsync_q);
  assign video_de = ~(hblank_q | vblank_q);
  assign INT      = int_q;
  assign EFx      = ~(((vi >= DISPLAY_START_LINE - 4) && (vi < DISPLAY_START_LINE)) ||
                      ((vi >= DISPLAY_START_LINE + DISPLAY_LINES - 4) &&
                       (vi < DISPLAY_START_LINE + DISPLAY_LINES)));
`ifdef PIXIE_UNDERRUN_EN
  assign dma_underrun = underrun_q;
`endif

endmodule

// File: doc/pixie_video_gen.md
PIXIE_VIDEO_GEN -- requirements
Module: pixie_video_gen

Interface
REQ-001 SHALL have parameter LINES_PER_FRAME, default 262, total lines per frame (312 for PAL).
REQ-002 SHALL have parameter PIXELS_PER_LINE, default 112, pixel ticks per line.
REQ-003 SHALL have parameter DISPLAY_START_LINE, default 64, first visible line.
REQ-004 SHALL have parameter DISPLAY_LINES, default 128, number of visible lines; must be a multiple of LINE_REPEAT.
REQ-005 SHALL have parameter BYTES_PER_ROW, default 8, range 1..14, DMA bytes per row group.
REQ-006 SHALL have parameter LINE_REPEAT, default 4, range 1..8, lines showing each fetched row.
REQ-007 SHALL have parameter H_ACTIVE_START, default 16, first visible pixel tick.
REQ-008 SHALL have parameter DMA_START, default 0, first tick of the DMA request window.
REQ-009 SHALL have ports: clk in 1 video clock; reset in 1 synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-010 SHALL have ports: clk_enable in 1 pixel tick; SC in 2 CPU state code; disp_on in 1; disp_off in 1; data_in in 8 DMA bus data.
REQ-011 SHALL have ports: video out 1; HSync, VSync, HBlank, VBlank out 1 each; csync out 1 = ~(HSync^VSync); video_de out 1 = ~(HBlank|VBlank).
REQ-012 SHALL have ports: DMAO out 1 active-low DMA request; INT out 1 active-high; EFx out 1 active-low frame flag.

Function
REQ-013 SHALL advance all counters and state only on clk_enable; h counter 0..PIXELS_PER_LINE-1, wraps and increments v counter 0..LINES_PER_FRAME-1, which wraps to 0.
REQ-014 SHALL set display_enabled on disp_on, clear on disp_off; disp_on wins when both are asserted together.
REQ-015 SHALL define fetch line as v = DISPLAY_START_LINE-1+k*LINE_REPEAT, for k = 0..DISPLAY_LINES/LINE_REPEAT-1.
REQ-016 SHALL drive DMAO low when display_enabled, on a fetch line, with DMA_START <= h < DMA_START+BYTES_PER_ROW*8, and high at all other times.
REQ-017 SHALL, while DMAO is low and on each clk_enable with SC==2, write data_in to fetch_buf[wr_ptr] and increment wr_ptr, which saturates at BYTES_PER_ROW; further bytes are ignored.
REQ-018 SHALL, at the h wrap of a fetch line, copy fetch_buf to disp_buf in one cycle and clear wr_ptr; the copied row is shown on the next LINE_REPEAT lines.
REQ-019 SHALL output video = disp_buf[(h-H_ACTIVE_START)>>3] bit 7-((h-H_ACTIVE_START)&7) for visible ticks, else 0; the output is registered with 1 tick latency and forced to 0 while display is disabled.
REQ-020 SHALL define visible ticks as H_ACTIVE_START <= h < H_ACTIVE_START+8*BYTES_PER_ROW, and visible lines as DISPLAY_START_LINE <= v < DISPLAY_START_LINE+DISPLAY_LINES.
REQ-021 SHALL set HBlank when the tick is not visible and VBlank when the line is not visible; both are registered and aligned with video.
REQ-022 SHALL set HSync high for h in [2,10) and VSync high for v in [2,4).
REQ-023 SHALL set INT when display_enabled at v=DISPLAY_START_LINE-2, h=0, and hold it until v=DISPLAY_START_LINE, h=0, or earlier on clk_enable with SC==3 (acknowledge).
REQ-024 SHALL drive EFx low for v in [DISPLAY_START_LINE-4, DISPLAY_START_LINE) and for the last 4 visible lines, independent of display_enabled.
REQ-025 SHALL, on disp_off during a DMA window, raise DMAO at the next tick and stop captures; disp_buf keeps its content.

Reset
REQ-026 SHALL on reset clear the h and v counters, wr_ptr, display_enabled, fetch_buf and disp_buf (all 0).
REQ-027 SHALL on reset drive video=0, DMAO=1, INT=0, EFx=1, HSync=0, VSync=0, HBlank=1, VBlank=1.
REQ-028 SHALL give reset priority over clk_enable and all other inputs, including reset during a DMA window.

Configuration
REQ-029 SHALL, with macro PIXIE_UNDERRUN_EN defined, add output dma_underrun (1 bit). It is a sticky flag set when a fetch line ends with wr_ptr < BYTES_PER_ROW, and the unfilled disp_buf bytes are loaded with 0. The flag is cleared only by reset or disp_on.
REQ-030 SHALL, without PIXIE_UNDERRUN_EN, omit the port, and the unfilled bytes keep their previous disp_buf value.

Verification
REQ-031 Reset, then free-run with clk_enable=1 every cycle -> frame period 262*112 ticks; VSync high on lines 2-3; EFx low on lines 60-63 and 188-191.
REQ-032 disp_on, then answer every DMAO-low tick with SC=2 and data 0x80,0x01,0xFF,... -> 8 bytes captured per fetch line, and line 64 pixel 16 = 1, pixel 17 = 0.
REQ-033 Same row shown on lines 64-67; the fetch on line 67 with new data appears on line 68.
REQ-034 INT rises at line 62, h=0; SC=3 at line 62, h=40 -> INT low on the next tick; with no acknowledge, INT falls at line 64, h=0.
REQ-035 Only 5 SC=2 cycles in a window -> with PIXIE_UNDERRUN_EN: dma_underrun=1 and bytes 5-7 shown as 0; without it: bytes 5-7 unchanged.
REQ-036 Reset asserted mid DMA window with PAL parameters (312 lines) -> all outputs take their reset values on the next clk edge, and the frame restarts at v=0.
